// File: rtl/rll_key_load_ctrl.sv
// Serial key loader for an RLL-locked netlist: collects KEY_W/SEG_W segments, verifies an XOR-fold check beat,
// and only then drives key_out. Optional build macro RLL_KEY_OTP_EN makes an armed key one-time-programmable.
module rll_key_load_ctrl #(
    parameter int KEY_W   = 16,
    parameter int SEG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             seg_valid,
    input  logic [SEG_W-1:0] seg_data,
    output logic             seg_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int N  = KEY_W / SEG_W;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    generate
        if (KEY_W % SEG_W != 0) begin : g_bad_width
            $error("rll_key_load_ctrl: KEY_W must be a multiple of SEG_W");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("rll_key_load_ctrl: TIMEOUT must be >= 1");
        end
    endgenerate

    logic [1:0]       state;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nxt;
    logic [CW-1:0]    beat_cnt;
    logic [SEG_W-1:0] fold;
    logic [TW-1:0]    to_cnt;

    assign seg_ready = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD);

    // Data beat k lands in the k-th segment from the top, so the first beat is the key MSBs.
    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < N; k++) begin
            if (beat_cnt == CW'(k)) begin
                shadow_nxt[KEY_W-1-k*SEG_W -: SEG_W] = seg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            beat_cnt  <= '0;
            fold      <= '0;
            to_cnt    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !clear) begin
                        state    <= ST_LOAD;
                        shadow   <= '0;
                        beat_cnt <= '0;
                        fold     <= '0;
                        to_cnt   <= '0;
                    end
                end

                ST_LOAD: begin
                    if (clear) begin
                        state    <= ST_IDLE;
                        shadow   <= '0;
                        beat_cnt <= '0;
                        fold     <= '0;
                        to_cnt   <= '0;
                    end else if (seg_valid) begin
                        to_cnt <= '0;
                        if (beat_cnt == CW'(N)) begin
                            if (seg_data == fold) begin
                                state     <= ST_ARMED;
                                key_out   <= shadow;
                                key_valid <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                            end
                        end else begin
                            shadow   <= shadow_nxt;
                            fold     <= fold ^ seg_data;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else begin
                        // The idle edge that would bring the counter to TIMEOUT is the one that gives up.
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TW'(TIMEOUT - 1)) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end

                ST_ARMED: begin
`ifdef RLL_KEY_OTP_EN
                    state <= ST_ARMED;
`else
                    if (clear) begin
                        state     <= ST_IDLE;
                        key_out   <= '0;
                        key_valid <= 1'b0;
                    end else if (start) begin
                        state     <= ST_LOAD;
                        key_out   <= '0;
                        key_valid <= 1'b0;
                        shadow    <= '0;
                        beat_cnt  <= '0;
                        fold      <= '0;
                        to_cnt    <= '0;
                    end
`endif
                end

                ST_ERROR: begin
                    if (clear) begin
                        state <= ST_IDLE;
                        err   <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    key_out   <= '0;
                    key_valid <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rll_key_load_ctrl.sv
// Directed bench for rll_key_load_ctrl (TIMEOUT=8); follows RLL_KEY_OTP_EN when it is defined for the build.
module tb_rll_key_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic        segValid;
    logic [3:0]  segData;
    logic        segReady;
    logic [15:0] keyOut;
    logic        keyValid;
    logic        busy;
    logic        err;

    int checkCount;
    int errorCount;

    rll_key_load_ctrl #(
        .KEY_W   (16),
        .SEG_W   (4),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .seg_valid (segValid),
        .seg_data  (segData),
        .seg_ready (segReady),
        .key_out   (keyOut),
        .key_valid (keyValid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs from the falling edge, then return just after the rising edge that used them.
    task automatic applyStimulus(input logic s, input logic c, input logic v, input logic [3:0] d);
        @(negedge clk);
        start    = s;
        clear    = c;
        segValid = v;
        segData  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expKey, input logic expKv,
                               input logic expBusy, input logic expErr, input logic expReady);
        checkCount++;
        assert ({keyOut, keyValid, busy, err, segReady} === {expKey, expKv, expBusy, expErr, expReady})
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed key=%h kv=%b busy=%b err=%b ready=%b, expected key=%h kv=%b busy=%b err=%b ready=%b",
                   tag, keyOut, keyValid, busy, err, segReady, expKey, expKv, expBusy, expErr, expReady);
        end
    endtask

    task automatic loadBeats(input logic [15:0] key);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, key[15-4*i -: 4]);
        end
    endtask

    task automatic syncReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        segValid = 1'b0;
        segData  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A beat offered in IDLE must not be taken into the next load.
        applyStimulus(0, 0, 1, 4'hF);
        checkOutput("idle_beat", 16'h0000, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 4'h0);
        checkOutput("load_entry", 16'h0000, 0, 1, 0, 1);
        loadBeats(16'hA5C3);
        checkOutput("data_beats_hidden", 16'h0000, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 4'h0);
        checkOutput("armed_a5c3", 16'hA5C3, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 4'h7);
        checkOutput("armed_beat_ignored", 16'hA5C3, 1, 0, 0, 0);

`ifdef RLL_KEY_OTP_EN
        applyStimulus(1, 0, 0, 4'h0);
        checkOutput("otp_start_ignored", 16'hA5C3, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("otp_clear_ignored", 16'hA5C3, 1, 0, 0, 0);
`else
        applyStimulus(1, 0, 0, 4'h0);
        checkOutput("reload_zeroed", 16'h0000, 0, 1, 0, 1);
        loadBeats(16'h1234);
        checkOutput("reload_hidden", 16'h0000, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 4'h4);
        checkOutput("armed_1234", 16'h1234, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("armed_clear", 16'h0000, 0, 0, 0, 0);
`endif
        syncReset();

        applyStimulus(1, 0, 0, 4'h0);
        loadBeats(16'hA5C3);
        applyStimulus(0, 0, 1, 4'h1);
        checkOutput("bad_check", 16'h0000, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 4'h0);
        checkOutput("error_sticky", 16'h0000, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("error_clear", 16'h0000, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(0, 0, 1, 4'hF);
        repeat (7) applyStimulus(0, 0, 0, 4'h0);
        checkOutput("timeout_7_idle", 16'h0000, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 4'h0);
        checkOutput("timeout_8_idle", 16'h0000, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("timeout_clear", 16'h0000, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(0, 0, 1, 4'hA);
        applyStimulus(0, 0, 1, 4'h5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 0, 0, 4'h0);
        checkOutput("start_in_load", 16'h0000, 0, 1, 0, 1);
        loadBeats(16'hA5C3);
        applyStimulus(0, 0, 1, 4'h0);
        checkOutput("post_reset_load", 16'hA5C3, 1, 0, 0, 0);
        syncReset();

        applyStimulus(1, 1, 0, 4'h0);
        checkOutput("start_clear_idle", 16'h0000, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0);
        loadBeats(16'hA5C3);
        applyStimulus(0, 1, 1, 4'h0);
        checkOutput("clear_with_check", 16'h0000, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
